wb_regport_arbiter: RTL and testbench
=====================================

WB_REGPORT_ARBITER -- requirements
Module: wb_regport_arbiter

Interface
REQ-001 SHALL have parameters: NBITS, 32, datapath width; NREG_BITS, 5, register address width; STARVE_MAX, 4, consecutive denied debug cycles before forced grant.
REQ-002 SHALL have ports: i_clk  in  1  single clock, rising edge; i_reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have pipeline ports: i_wb_valid in 1 WB slot valid; i_wb_reg_write in 1 write enable; i_wb_jal in 1 JAL; i_wb_rd in NREG_BITS dest; i_wb_memdatos in NBITS data; i_wb_pc_8 in NBITS PC+8.
REQ-004 SHALL have debug ports: i_dbg_req in 1; i_dbg_wr in 1 (1=write, 0=read); i_dbg_addr in NREG_BITS; i_dbg_wdata in NBITS; o_dbg_ack out 1; o_dbg_rdata out NBITS.
REQ-005 SHALL have register-file ports: o_rf_we out 1; o_rf_addr out NREG_BITS; o_rf_wdata out NBITS; o_rf_raddr out NREG_BITS; i_rf_rdata in NBITS; o_stall out 1 (pipeline freeze).

Function
REQ-006 SHALL implement FSM states IDLE, PIPE_WR, DBG_ACC, DBG_ACK.
REQ-007 Pipeline request SHALL be i_wb_valid & i_wb_reg_write; debug request SHALL be i_dbg_req while in IDLE or PIPE_WR.
REQ-008 Pipeline request with no forced grant SHALL enter PIPE_WR; next cycle o_rf_we=1, o_rf_addr=rd, o_rf_wdata=selected data (1-cycle latency).
REQ-009 Data select SHALL be i_wb_pc_8 when i_wb_jal=1, else i_wb_memdatos; JAL SHALL force o_rf_addr=31 regardless of i_wb_rd.
REQ-010 Any write targeting address 0 SHALL be suppressed (o_rf_we=0); the transaction otherwise completes normally.
REQ-011 Debug request with no pipeline request SHALL enter DBG_ACC: write -> o_rf_we=1, addr/data from debug; read -> o_rf_raddr=i_dbg_addr, o_rf_we=0.
REQ-012 DBG_ACC SHALL always go to DBG_ACK; DBG_ACK SHALL pulse o_dbg_ack=1 for exactly one cycle, load o_dbg_rdata=i_rf_rdata on reads (hold value on writes), then return to IDLE.
REQ-013 Simultaneous pipeline and debug requests SHALL grant the pipeline, unless the starvation counter equals STARVE_MAX (REQ-019).
REQ-014 o_stall SHALL be 1 in DBG_ACC and DBG_ACK, 0 otherwise; pipeline requests presented while stalled SHALL be ignored (the pipeline holds them).
REQ-015 i_dbg_req SHALL be held until o_dbg_ack; deasserting early is illegal and the access SHALL still complete.
REQ-016 Back-to-back pipeline writes SHALL be accepted every cycle (PIPE_WR->PIPE_WR) without bubbles.
REQ-017 o_rf_we SHALL be 1 for exactly one cycle per accepted write.

Reset
REQ-018 On i_reset=0, asynchronously: state=IDLE, o_rf_we=0, o_rf_addr=0, o_rf_wdata=0, o_rf_raddr=0, o_dbg_ack=0, o_dbg_rdata=0, o_stall=0, starvation counter=0; reset mid-transaction SHALL abort it with no ack.

Configuration
REQ-019 With WB_ARB_STARVE_EN defined: a counter SHALL increment on each cycle a debug request is denied, saturate at STARVE_MAX, force the debug grant when at STARVE_MAX, and clear on every debug grant.
REQ-020 Without WB_ARB_STARVE_EN: no counter; debug SHALL be granted only on cycles with no pipeline request (strict pipeline priority).

Verification
REQ-021 Pipeline write rd=5, memdatos=0xDEADBEEF, jal=0 -> next cycle o_rf_we=1, addr=5, wdata=0xDEADBEEF.
REQ-022 JAL with rd=7, pc_8=0x00000108 -> o_rf_addr=31, o_rf_wdata=0x00000108; write with rd=0 -> o_rf_we stays 0.
REQ-023 Debug read addr=3 with i_rf_rdata=0x12345678, pipeline idle -> o_stall high 2 cycles, o_dbg_ack one-cycle pulse, o_dbg_rdata=0x12345678.
REQ-024 WB_ARB_STARVE_EN on, continuous pipeline writes plus debug write request -> 4 pipeline writes, then debug grant, stall, ack; macro off -> debug waits until pipeline idle.
REQ-025 Assert i_reset=0 during DBG_ACC -> all outputs 0 immediately, no o_dbg_ack, FSM in IDLE after release.

Source files
------------

// File: rtl/wb_regport_arbiter.sv
// wb_regport_arbiter
// Shares the single register-file write/read port between the pipeline
// write-back stage and a debug access port. The pipeline normally has
// priority. A debug access takes two stalled cycles: an access cycle that
// drives the register file, then an acknowledge cycle that returns read data.
//
// Build option: define WB_ARB_STARVE_EN to enable the debug starvation guard.
// With it, after STARVE_MAX consecutive cycles of denied debug requests the
// debug port is granted even if the pipeline is requesting. Without it, the
// pipeline has strict priority.
//
// In a forced-grant cycle the pipeline write offered on that cycle is not
// accepted; o_stall rises on the following cycle and freezes the pipeline.

module wb_regport_arbiter #(
    parameter int NBITS      = 32,
    parameter int NREG_BITS  = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,

    input  logic                 i_wb_valid,
    input  logic                 i_wb_reg_write,
    input  logic                 i_wb_jal,
    input  logic [NREG_BITS-1:0] i_wb_rd,
    input  logic [NBITS-1:0]     i_wb_memdatos,
    input  logic [NBITS-1:0]     i_wb_pc_8,

    input  logic                 i_dbg_req,
    input  logic                 i_dbg_wr,
    input  logic [NREG_BITS-1:0] i_dbg_addr,
    input  logic [NBITS-1:0]     i_dbg_wdata,
    output logic                 o_dbg_ack,
    output logic [NBITS-1:0]     o_dbg_rdata,

    output logic                 o_rf_we,
    output logic [NREG_BITS-1:0] o_rf_addr,
    output logic [NBITS-1:0]     o_rf_wdata,
    output logic [NREG_BITS-1:0] o_rf_raddr,
    input  logic [NBITS-1:0]     i_rf_rdata,
    output logic                 o_stall
);

    // JAL always links into the last architectural register.
    localparam logic [NREG_BITS-1:0] LINK_REG = NREG_BITS'(31);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PIPE_WR = 2'd1,
        DBG_ACC = 2'd2,
        DBG_ACK = 2'd3
    } state_t;

    state_t state;

    // Direction of the debug access in flight; the requester may drop its
    // inputs once granted, so the access cycle must not look at i_dbg_wr.
    logic dbg_is_write;

    logic                 arb_phase;
    logic                 pipe_req;
    logic                 dbg_req;
    logic                 force_dbg;
    logic                 grant_pipe;
    logic                 grant_dbg;
    logic [NREG_BITS-1:0] pipe_addr;
    logic [NBITS-1:0]     pipe_data;

    // New requests are only arbitrated while the port is not busy with debug.
    assign arb_phase  = (state == IDLE) || (state == PIPE_WR);
    assign pipe_req   = i_wb_valid & i_wb_reg_write;
    assign dbg_req    = i_dbg_req & arb_phase;
    assign grant_pipe = arb_phase & pipe_req & ~force_dbg;
    assign grant_dbg  = dbg_req & ~grant_pipe;

    // Write-back data/destination selection: JAL writes the link address.
    assign pipe_addr  = i_wb_jal ? LINK_REG : i_wb_rd;
    assign pipe_data  = i_wb_jal ? i_wb_pc_8 : i_wb_memdatos;

`ifdef WB_ARB_STARVE_EN
    localparam int                SCW         = $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0]    STARVE_LIM  = SCW'(STARVE_MAX);

    logic [SCW-1:0] starve_cnt;

    assign force_dbg = dbg_req && (starve_cnt == STARVE_LIM);

    // Count consecutive denied debug cycles, saturating, cleared on any debug grant.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            starve_cnt <= '0;
        end else if (grant_dbg) begin
            starve_cnt <= '0;
        end else if (dbg_req && grant_pipe && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + SCW'(1);
        end
    end
`else
    // Strict pipeline priority: the starvation limit has no effect here.
    assign force_dbg = (STARVE_MAX < 0);
`endif

    // Arbitration FSM with registered register-file and debug outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            dbg_is_write <= 1'b0;
            o_rf_we      <= 1'b0;
            o_rf_addr    <= '0;
            o_rf_wdata   <= '0;
            o_rf_raddr   <= '0;
            o_dbg_ack    <= 1'b0;
            o_dbg_rdata  <= '0;
            o_stall      <= 1'b0;
        end else begin
            // Write enable and acknowledge are single-cycle pulses.
            o_rf_we   <= 1'b0;
            o_dbg_ack <= 1'b0;

            case (state)
                IDLE, PIPE_WR: begin
                    if (grant_pipe) begin
                        state      <= PIPE_WR;
                        o_stall    <= 1'b0;
                        o_rf_addr  <= pipe_addr;
                        o_rf_wdata <= pipe_data;
                        // Register 0 is hardwired; the transfer completes silently.
                        o_rf_we    <= (pipe_addr != '0);
                    end else if (grant_dbg) begin
                        state        <= DBG_ACC;
                        o_stall      <= 1'b1;
                        dbg_is_write <= i_dbg_wr;
                        if (i_dbg_wr) begin
                            o_rf_addr  <= i_dbg_addr;
                            o_rf_wdata <= i_dbg_wdata;
                            o_rf_we    <= (i_dbg_addr != '0);
                        end else begin
                            o_rf_raddr <= i_dbg_addr;
                        end
                    end else begin
                        state   <= IDLE;
                        o_stall <= 1'b0;
                    end
                end

                DBG_ACC: begin
                    // Read data is valid while o_rf_raddr is held in the access cycle.
                    state     <= DBG_ACK;
                    o_stall   <= 1'b1;
                    o_dbg_ack <= 1'b1;
                    if (!dbg_is_write) begin
                        o_dbg_rdata <= i_rf_rdata;
                    end
                end

                DBG_ACK: begin
                    state   <= IDLE;
                    o_stall <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    o_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_regport_arbiter.sv
// Self-checking bench for wb_regport_arbiter: directed scenarios followed by
// randomized traffic, compared against a transaction-level model of the
// arbitration rules. Honors WB_ARB_STARVE_EN the same way the design does.

module tb_wb_regport_arbiter;

    localparam int NBITS      = 32;
    localparam int NREG_BITS  = 5;
    localparam int STARVE_MAX = 4;
`ifdef WB_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic                 i_wb_valid;
    logic                 i_wb_reg_write;
    logic                 i_wb_jal;
    logic [NREG_BITS-1:0] i_wb_rd;
    logic [NBITS-1:0]     i_wb_memdatos;
    logic [NBITS-1:0]     i_wb_pc_8;
    logic                 i_dbg_req;
    logic                 i_dbg_wr;
    logic [NREG_BITS-1:0] i_dbg_addr;
    logic [NBITS-1:0]     i_dbg_wdata;
    logic                 o_dbg_ack;
    logic [NBITS-1:0]     o_dbg_rdata;
    logic                 o_rf_we;
    logic [NREG_BITS-1:0] o_rf_addr;
    logic [NBITS-1:0]     o_rf_wdata;
    logic [NREG_BITS-1:0] o_rf_raddr;
    logic [NBITS-1:0]     i_rf_rdata;
    logic                 o_stall;

    int n_checks = 0;
    int n_pass   = 0;

    wb_regport_arbiter #(
        .NBITS      (NBITS),
        .NREG_BITS  (NREG_BITS),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_wb_valid     (i_wb_valid),
        .i_wb_reg_write (i_wb_reg_write),
        .i_wb_jal       (i_wb_jal),
        .i_wb_rd        (i_wb_rd),
        .i_wb_memdatos  (i_wb_memdatos),
        .i_wb_pc_8      (i_wb_pc_8),
        .i_dbg_req      (i_dbg_req),
        .i_dbg_wr       (i_dbg_wr),
        .i_dbg_addr     (i_dbg_addr),
        .i_dbg_wdata    (i_dbg_wdata),
        .o_dbg_ack      (o_dbg_ack),
        .o_dbg_rdata    (o_dbg_rdata),
        .o_rf_we        (o_rf_we),
        .o_rf_addr      (o_rf_addr),
        .o_rf_wdata     (o_rf_wdata),
        .o_rf_raddr     (o_rf_raddr),
        .i_rf_rdata     (i_rf_rdata),
        .o_stall        (o_stall)
    );

    always #5 i_clk = ~i_clk;

    // Register file attached to the arbiter: synchronous write, asynchronous read.
    logic [NBITS-1:0] rf_mem [32] = '{default: '0};
    always @(posedge i_clk) begin
        if (o_rf_we) rf_mem[o_rf_addr] <= o_rf_wdata;
    end
    assign i_rf_rdata = rf_mem[o_rf_raddr];

    // ---------------- reference model ----------------
    logic [NBITS-1:0]     model_rf [32] = '{default: '0};
    int                   m_left;       // debug cycles still owed (access, ack)
    int                   m_denied;     // consecutive cycles debug has waited
    bit                   m_dbg_wr;
    logic [NREG_BITS-1:0] m_dbg_addr;
    bit                   exp_we;
    logic [NREG_BITS-1:0] exp_addr;
    logic [NBITS-1:0]     exp_wdata;
    bit                   exp_ack;
    logic [NBITS-1:0]     exp_rdata;
    bit                   exp_stall;

    task automatic reset_model();
        m_left     = 0;
        m_denied   = 0;
        m_dbg_wr   = 1'b0;
        m_dbg_addr = '0;
        exp_we     = 1'b0;
        exp_addr   = '0;
        exp_wdata  = '0;
        exp_ack    = 1'b0;
        exp_rdata  = '0;
        exp_stall  = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit                   pipe;
        bit                   dreq;
        bit                   forced;
        logic [NREG_BITS-1:0] a;
        if (exp_we) model_rf[exp_addr] = exp_wdata;
        exp_we  = 1'b0;
        exp_ack = 1'b0;
        pipe    = i_wb_valid && i_wb_reg_write;
        if (m_left == 2) begin
            exp_ack   = 1'b1;
            exp_stall = 1'b1;
            if (!m_dbg_wr) exp_rdata = model_rf[m_dbg_addr];
            m_left = 1;
        end else if (m_left == 1) begin
            exp_stall = 1'b0;
            m_left    = 0;
        end else begin
            dreq   = i_dbg_req;
            forced = STARVE_ON && dreq && (m_denied >= STARVE_MAX);
            if (pipe && !forced) begin
                a         = i_wb_jal ? 5'd31 : i_wb_rd;
                exp_addr  = a;
                exp_wdata = i_wb_jal ? i_wb_pc_8 : i_wb_memdatos;
                exp_we    = (a != 0);
                exp_stall = 1'b0;
                if (dreq && m_denied < STARVE_MAX) m_denied++;
            end else if (dreq) begin
                m_denied   = 0;
                m_left     = 2;
                m_dbg_wr   = i_dbg_wr;
                m_dbg_addr = i_dbg_addr;
                exp_stall  = 1'b1;
                if (i_dbg_wr) begin
                    exp_addr  = i_dbg_addr;
                    exp_wdata = i_dbg_wdata;
                    exp_we    = (i_dbg_addr != 0);
                end
            end else begin
                exp_stall = 1'b0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    endtask

    task automatic check_outputs();
        check("rf_we", 32'(o_rf_we), 32'(exp_we));
        check("stall", 32'(o_stall), 32'(exp_stall));
        check("dbg_ack", 32'(o_dbg_ack), 32'(exp_ack));
        check("dbg_rdata", o_dbg_rdata, exp_rdata);
        if (exp_we) begin
            check("rf_addr", 32'(o_rf_addr), 32'(exp_addr));
            check("rf_wdata", o_rf_wdata, exp_wdata);
        end
        if (m_left == 2 && !m_dbg_wr) check("rf_raddr", 32'(o_rf_raddr), 32'(m_dbg_addr));
    endtask

    task automatic step();
        model_edge();
        @(posedge i_clk);
        #1;
        check_outputs();
    endtask

    task automatic set_pipe(input bit jal, input logic [NREG_BITS-1:0] rd,
                            input logic [NBITS-1:0] mem, input logic [NBITS-1:0] pc8);
        i_wb_valid     = 1'b1;
        i_wb_reg_write = 1'b1;
        i_wb_jal       = jal;
        i_wb_rd        = rd;
        i_wb_memdatos  = mem;
        i_wb_pc_8      = pc8;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_we"}, 32'(o_rf_we), 32'h0);
        check({pfx, "_addr"}, 32'(o_rf_addr), 32'h0);
        check({pfx, "_wdata"}, o_rf_wdata, 32'h0);
        check({pfx, "_raddr"}, 32'(o_rf_raddr), 32'h0);
        check({pfx, "_ack"}, 32'(o_dbg_ack), 32'h0);
        check({pfx, "_rdata"}, o_dbg_rdata, 32'h0);
        check({pfx, "_stall"}, 32'(o_stall), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  n_pw;
        int  n_st;
        bit  seen;
        bit  dbg_busy;

        i_reset        = 1'b0;
        i_wb_valid     = 1'b0;
        i_wb_reg_write = 1'b0;
        i_wb_jal       = 1'b0;
        i_wb_rd        = '0;
        i_wb_memdatos  = '0;
        i_wb_pc_8      = '0;
        i_dbg_req      = 1'b0;
        i_dbg_wr       = 1'b0;
        i_dbg_addr     = '0;
        i_dbg_wdata    = '0;
        reset_model();

        repeat (2) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_reset = 1'b1;

        // Plain pipeline write
        set_pipe(1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
        step();
        check("pw_we", 32'(o_rf_we), 32'h1);
        check("pw_addr", 32'(o_rf_addr), 32'd5);
        check("pw_wdata", o_rf_wdata, 32'hDEADBEEF);

        // JAL writes link register, back-to-back with previous write
        set_pipe(1'b1, 5'd7, 32'h0BAD0BAD, 32'h00000108);
        step();
        check("jal_we", 32'(o_rf_we), 32'h1);
        check("jal_addr", 32'(o_rf_addr), 32'd31);
        check("jal_wdata", o_rf_wdata, 32'h00000108);

        // Write to register 0 is suppressed
        set_pipe(1'b0, 5'd0, 32'h00000055, 32'h0);
        step();
        check("r0_we", 32'(o_rf_we), 32'h0);
        i_wb_valid = 1'b0;
        step();
        check("idle_we", 32'(o_rf_we), 32'h0);

        // Debug write to r3, request dropped right after grant
        i_dbg_req   = 1'b1;
        i_dbg_wr    = 1'b1;
        i_dbg_addr  = 5'd3;
        i_dbg_wdata = 32'h12345678;
        step();
        check("dw_stall", 32'(o_stall), 32'h1);
        check("dw_we", 32'(o_rf_we), 32'h1);
        check("dw_addr", 32'(o_rf_addr), 32'd3);
        i_dbg_req = 1'b0;
        step();
        check("dw_ack", 32'(o_dbg_ack), 32'h1);
        step();
        check("dw_done_ack", 32'(o_dbg_ack), 32'h0);
        check("dw_done_stall", 32'(o_stall), 32'h0);

        // Debug read of r3 with the pipeline idle
        i_dbg_req  = 1'b1;
        i_dbg_wr   = 1'b0;
        i_dbg_addr = 5'd3;
        step();
        check("dr_stall1", 32'(o_stall), 32'h1);
        check("dr_ack1", 32'(o_dbg_ack), 32'h0);
        check("dr_raddr", 32'(o_rf_raddr), 32'd3);
        step();
        check("dr_stall2", 32'(o_stall), 32'h1);
        check("dr_ack2", 32'(o_dbg_ack), 32'h1);
        check("dr_rdata", o_dbg_rdata, 32'h12345678);
        i_dbg_req = 1'b0;
        step();
        check("dr_stall3", 32'(o_stall), 32'h0);
        check("dr_ack3", 32'(o_dbg_ack), 32'h0);

        // Continuous pipeline writes competing with a debug write
        i_dbg_req   = 1'b1;
        i_dbg_wr    = 1'b1;
        i_dbg_addr  = 5'd12;
        i_dbg_wdata = $urandom();
        n_pw = 0;
        n_st = 0;
        seen = 1'b0;
`ifdef WB_ARB_STARVE_EN
        for (int c = 0; c < 20 && !seen; c++) begin
            set_pipe(1'b0, 5'($urandom_range(1, 30)), $urandom(), $urandom());
            step();
            if (o_stall) seen = 1'b1;
            else if (o_rf_we) n_pw++;
        end
        check("starve_pipe_writes", 32'(n_pw), 32'd4);
        check("starve_grant", 32'(seen), 32'h1);
        step();
        check("starve_ack", 32'(o_dbg_ack), 32'h1);
`else
        for (int c = 0; c < 8; c++) begin
            set_pipe(1'b0, 5'($urandom_range(1, 30)), $urandom(), $urandom());
            step();
            if (o_stall) n_st++;
            if (o_rf_we) n_pw++;
        end
        check("prio_no_stall", 32'(n_st), 32'd0);
        check("prio_pipe_writes", 32'(n_pw), 32'd8);
        i_wb_valid = 1'b0;
        step();
        check("prio_grant", 32'(o_stall), 32'h1);
        step();
        check("prio_ack", 32'(o_dbg_ack), 32'h1);
`endif
        i_dbg_req  = 1'b0;
        i_wb_valid = 1'b0;
        step();

        // Reset during a debug access cycle
        i_dbg_req  = 1'b1;
        i_dbg_wr   = 1'b0;
        i_dbg_addr = 5'd3;
        step();
        check("rm_pre_stall", 32'(o_stall), 32'h1);
        i_reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        reset_model();
        i_dbg_req = 1'b0;
        @(posedge i_clk);
        #1;
        check("rst_hold_ack", 32'(o_dbg_ack), 32'h0);
        i_reset = 1'b1;
        step();
        check("rst_after_ack", 32'(o_dbg_ack), 32'h0);
        check("rst_after_stall", 32'(o_stall), 32'h0);
        set_pipe(1'b0, 5'd9, 32'hCAFEF00D, 32'h0);
        step();
        check("rst_after_pw_we", 32'(o_rf_we), 32'h1);
        check("rst_after_pw_addr", 32'(o_rf_addr), 32'd9);
        i_wb_valid = 1'b0;
        step();

        // Randomized traffic
        dbg_busy = 1'b0;
        for (int c = 0; c < 400; c++) begin
            i_wb_valid     = ($urandom_range(0, 9) < 7);
            i_wb_reg_write = ($urandom_range(0, 3) != 0);
            i_wb_jal       = ($urandom_range(0, 4) == 0);
            i_wb_rd        = 5'($urandom_range(0, 31));
            i_wb_memdatos  = $urandom();
            i_wb_pc_8      = $urandom();
            if (!dbg_busy && $urandom_range(0, 5) == 0) begin
                dbg_busy    = 1'b1;
                i_dbg_req   = 1'b1;
                i_dbg_wr    = ($urandom_range(0, 1) == 1);
                i_dbg_addr  = 5'($urandom_range(0, 31));
                i_dbg_wdata = $urandom();
            end
            step();
            if (exp_ack) begin
                i_dbg_req = 1'b0;
                dbg_busy  = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
